// File: rtl/ops.sv
// ops: shared opcode encodings and shifter mode constants for the execute-stage ALU
package ops;
    typedef enum logic [3:0] {
        ADD_OP      = 4'd0,
        SUB_OP      = 4'd1,
        MUL_OP      = 4'd2,
        LL_SHIFT_OP = 4'd3,
        LR_SHIFT_OP = 4'd4,
        AR_SHIFT_OP = 4'd5,
        NOT_OP      = 4'd6,
        AND_OP      = 4'd7,
        OR_OP       = 4'd8,
        XOR_OP      = 4'd9
    } opcode_t;
    localparam logic [1:0] SH_LL = 2'd0;
    localparam logic [1:0] SH_LR = 2'd1;
    localparam logic [1:0] SH_AR = 2'd2;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational barrel shifter (logical left, logical right, arithmetic right)
module alu_shifter import ops::*; #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] y
);
    // full unsigned shift amount: oversize shifts naturally yield zero or sign fill
    always_comb y = mode == SH_LL ? a << b : mode == SH_LR ? a >> b : WIDTH'($signed(a) >>> b);
endmodule

// File: rtl/alu.sv
// alu: registered integer ALU with status flags; define ALU_MUL_EN to add the unsigned multiplier
module alu import ops::*; #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);
    opcode_t          op;
    logic             sub;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [1:0]       mode;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] ny;
    logic             nc;
    logic             nv;
    assign op   = opcode_t'(opcode);
    assign sub  = op == SUB_OP;
    assign bb   = sub ? ~b : b;
    assign sum  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub ? 1'b1 : cin};
    assign ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign mode = op == LL_SHIFT_OP ? SH_LL : op == LR_SHIFT_OP ? SH_LR : SH_AR;
`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif
    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .a    (a),
        .b    (b),
        .mode (mode),
        .y    (sh)
    );
    // next result and carry/overflow; reserved opcodes fall through to all-zero
    always_comb begin
        ny = '0;
        nc = 1'b0;
        nv = 1'b0;
        case (op)
            ADD_OP, SUB_OP: begin
                ny = sum[WIDTH-1:0];
                nc = sum[WIDTH];
                nv = ovf;
            end
`ifdef ALU_MUL_EN
            MUL_OP: begin
                ny = prod[WIDTH-1:0];
                nc = |prod[2*WIDTH-1:WIDTH];
            end
`endif
            LL_SHIFT_OP, LR_SHIFT_OP, AR_SHIFT_OP: ny = sh;
            NOT_OP: ny = ~a;
            AND_OP: ny = a & b;
            OR_OP:  ny = a | b;
            XOR_OP: ny = a ^ b;
            default: ny = '0;
        endcase
    end
    // output register; negative and zero derive from the result being captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y        <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
            zero     <= 1'b1;
        end else begin
            y        <= ny;
            cout     <= nc;
            overflow <= nv;
            negative <= ny[WIDTH-1];
            zero     <= ~|ny;
        end
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vector table, async reset sequence and randomized back-to-back ops vs integer model
module tb_alu;
    localparam int W = 4;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   opcode;
    logic [W-1:0] a, b, y;
    logic         cin, cout, overflow, negative, zero;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .y        (y),
        .cout     (cout),
        .overflow (overflow),
        .negative (negative),
        .zero     (zero)
    );

    // expected outputs packed as {y[3:0], cout, overflow, negative, zero}
    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [7:0] exp;
    } vec_t;

    function automatic logic [7:0] model(input int op, input int av, input int bv, input int ci);
        int sa, sb, r, yv;
        logic co, ov;
        logic [3:0] y4;
        sa = av >= 8 ? av - 16 : av;
        sb = bv >= 8 ? bv - 16 : bv;
        yv = 0;
        co = 1'b0;
        ov = 1'b0;
        case (op)
            0: begin
                r  = av + bv + ci;
                yv = r % 16;
                co = r >= 16;
                ov = (sa + sb + ci > 7) || (sa + sb + ci < -8);
            end
            1: begin
                yv = (av - bv + 16) % 16;
                co = av >= bv;
                ov = (sa - sb > 7) || (sa - sb < -8);
            end
`ifdef ALU_MUL_EN
            2: begin
                r  = av * bv;
                yv = r % 16;
                co = r >= 16;
            end
`endif
            3: yv = bv >= 4 ? 0 : (av << bv) % 16;
            4: yv = av >> bv;
            5: yv = (sa >>> bv) & 15;
            6: yv = 15 - av;
            7: yv = av & bv;
            8: yv = av | bv;
            9: yv = av ^ bv;
            default: yv = 0;
        endcase
        y4 = yv[3:0];
        return {y4, co, ov, yv >= 8, yv == 0};
    endfunction

    task automatic check(input string nm, input logic [7:0] exp);
        logic [7:0] act;
        act = {y, cout, overflow, negative, zero};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got y,c,v,n,z=%b required %b", nm, act, exp);
        end
    endtask

    vec_t vecs[16];
    logic [7:0] pend;

    initial begin
        vecs[0]  = '{4'd3, 4'b0001, 4'b0001, 1'b0, 8'b0010_0000};
        vecs[1]  = '{4'd4, 4'b0001, 4'b0001, 1'b0, 8'b0000_0001};
        vecs[2]  = '{4'd5, 4'b1001, 4'b0001, 1'b0, 8'b1100_0010};
        vecs[3]  = '{4'd5, 4'b1001, 4'b0101, 1'b0, 8'b1111_0010};
        vecs[4]  = '{4'd6, 4'b1000, 4'b0000, 1'b0, 8'b0111_0000};
        vecs[5]  = '{4'd7, 4'b1111, 4'b0111, 1'b0, 8'b0111_0000};
        vecs[6]  = '{4'd8, 4'b1010, 4'b0101, 1'b0, 8'b1111_0010};
        vecs[7]  = '{4'd9, 4'b1100, 4'b1010, 1'b0, 8'b0110_0000};
        vecs[8]  = '{4'd0, 4'b0111, 4'b0001, 1'b0, 8'b1000_0110};
        vecs[9]  = '{4'd0, 4'b1111, 4'b0000, 1'b1, 8'b0000_1001};
        vecs[10] = '{4'd1, 4'b0011, 4'b0101, 1'b1, 8'b1110_0010};
`ifdef ALU_MUL_EN
        vecs[11] = '{4'd2, 4'b0011, 4'b0101, 1'b0, 8'b1111_0010};
`else
        vecs[11] = '{4'd2, 4'b0011, 4'b0101, 1'b0, 8'b0000_0001};
`endif
        vecs[12] = '{4'd15, 4'b1111, 4'b1111, 1'b1, 8'b0000_0001};
        vecs[13] = '{4'd3, 4'b1111, 4'b0100, 1'b0, 8'b0000_0001};
        vecs[14] = '{4'd4, 4'b1000, 4'b1111, 1'b0, 8'b0000_0001};
        vecs[15] = '{4'd1, 4'b1000, 4'b0001, 1'b0, 8'b0111_1100};

        rst = 1'b1;
        opcode = '0;
        a = '0;
        b = '0;
        cin = 1'b0;
        #12;
        check("reset_state", 8'b0000_0001);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            opcode = vecs[i].op;
            a      = vecs[i].a;
            b      = vecs[i].b;
            cin    = vecs[i].cin;
            @(negedge clk);
            check($sformatf("vec%0d_op%0d", i, vecs[i].op), vecs[i].exp);
        end

        @(negedge clk);
        opcode = 4'd6;
        a = 4'b1000;
        b = 4'b0000;
        @(negedge clk);
        check("pre_reset", 8'b0111_0000);
        #2 rst = 1'b1;
        #1 check("async_reset", 8'b0000_0001);
        @(posedge clk);
        #1 check("reset_hold", 8'b0000_0001);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset", 8'b0111_0000);

        opcode = 4'($urandom_range(0, 15));
        a      = 4'($urandom);
        b      = 4'($urandom);
        cin    = 1'($urandom);
        pend   = model(int'(opcode), int'(a), int'(b), int'(cin));
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            check($sformatf("rand%0d", i), pend);
            opcode = 4'($urandom_range(0, 15));
            a      = 4'($urandom);
            b      = 4'($urandom);
            cin    = 1'($urandom);
            pend   = model(int'(opcode), int'(a), int'(b), int'(cin));
        end
        @(negedge clk);
        check("rand_last", pend);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
